// File: rtl/button_chord_capture.sv
// -----------------------------------------------------------------------------
// button_chord_capture
//
// Conditions the raw 10-key pad for the calculator FSM. The raw key levels are
// synchronized, and keys pressed together are merged into one chord over a
// settle window. Each legal code is then issued as a one-cycle registered
// pulse. After that the block waits for a debounced full release before it
// accepts the next press.
//
// Optional feature (compile-time macro BUTTON_AUTO_REPEAT_EN):
//   A single-hot digit held unchanged is re-emitted every 16*CHORD_WINDOW
//   cycles. Operator, EQUAL and CLEAR chords never repeat.
//
// Parameters:
//   CHORD_WINDOW    - synchronized samples ORed into a chord (>= 1)
//   DEBOUNCE_CYCLES - consecutive all-zero samples that declare release (>= 1)
//
// Ports:
//   clk          in   system clock, rising edge
//   clear        in   asynchronous active-high reset
//   button_raw   in   [9:0] raw key levels, asynchronous to clk (bit n = key n)
//   button       out  [9:0] captured key code, nonzero only with button_valid
//   button_valid out  one-cycle strobe qualifying button
//   chord_err    out  one-cycle strobe for an illegal chord
//   busy         out  high in every state except IDLE
// -----------------------------------------------------------------------------
module button_chord_capture #(
  parameter int unsigned CHORD_WINDOW    = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [9:0] button_raw,
  output logic [9:0] button,
  output logic       button_valid,
  output logic       chord_err,
  output logic       busy
);

  localparam int unsigned MAX_P = (CHORD_WINDOW > DEBOUNCE_CYCLES) ? CHORD_WINDOW : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_P) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(CHORD_WINDOW);
  // Release is declared on the edge that samples the last required zero.
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GATHER  = 2'd1,
    S_EMIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state_q;
  logic [9:0]       sync1_q;
  logic [9:0]       btn_s_q;
  logic [9:0]       acc_q;
  logic [CNT_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] rel_cnt_q;
  logic [9:0]       button_q;
  logic             valid_q;
  logic             err_q;
  logic             busy_q;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned REP_PERIOD = 16 * CHORD_WINDOW;
  localparam int unsigned REP_W      = $clog2(REP_PERIOD) + 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  logic [REP_W-1:0] rep_cnt_q;
`endif

  // Exactly one key pressed.
  function automatic logic is_onehot(input logic [9:0] code);
    is_onehot = (code != 10'd0) && ((code & (code - 10'd1)) == 10'd0);
  endfunction

  // Single digits plus the fixed operator/EQUAL/CLEAR chords.
  function automatic logic is_legal(input logic [9:0] code);
    case (code)
      10'h201, 10'h202, 10'h204, 10'h208, 10'h300, 10'h380: is_legal = 1'b1;
      default: is_legal = is_onehot(code);
    endcase
  endfunction

  // Synchronizer, chord FSM and registered strobes.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync1_q   <= 10'd0;
      btn_s_q   <= 10'd0;
      acc_q     <= 10'd0;
      win_cnt_q <= '0;
      rel_cnt_q <= '0;
      button_q  <= 10'd0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      state_q   <= S_IDLE;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt_q <= '0;
`endif
    end else begin
      sync1_q  <= button_raw;
      btn_s_q  <= sync1_q;
      // Strobes last one cycle unless a branch below raises them again.
      button_q <= 10'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (btn_s_q != 10'd0) begin
            acc_q     <= btn_s_q;
            win_cnt_q <= CNT_ONE;
            busy_q    <= 1'b1;
            state_q   <= S_GATHER;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_GATHER: begin
          if (btn_s_q == 10'd0) begin
            // Glitch: a key dropped before the window closed.
            acc_q     <= 10'd0;
            win_cnt_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else if (win_cnt_q == WIN_LAST) begin
            // acc already holds CHORD_WINDOW samples; this edge only confirms
            // the keys are still down and launches the pulse.
            if (is_legal(acc_q)) begin
              button_q <= acc_q;
              valid_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= S_EMIT;
          end else begin
            acc_q     <= acc_q | btn_s_q;
            win_cnt_q <= win_cnt_q + CNT_ONE;
          end
        end
        S_EMIT: begin
          rel_cnt_q <= '0;
          win_cnt_q <= '0;
          state_q   <= S_RELEASE;
`ifdef BUTTON_AUTO_REPEAT_EN
          rep_cnt_q <= '0;
`endif
        end
        S_RELEASE: begin
          if (btn_s_q != 10'd0) begin
            rel_cnt_q <= '0;
          end else if (rel_cnt_q == REL_LAST) begin
            acc_q     <= 10'd0;
            rel_cnt_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            rel_cnt_q <= rel_cnt_q + CNT_ONE;
          end
`ifdef BUTTON_AUTO_REPEAT_EN
          // Any change of the held keys restarts the repeat timer.
          if (btn_s_q == acc_q) begin
            if (rep_cnt_q == REP_LAST) begin
              rep_cnt_q <= '0;
              if (is_onehot(acc_q)) begin
                button_q <= acc_q;
                valid_q  <= 1'b1;
              end else begin
                valid_q <= 1'b0;
              end
            end else begin
              rep_cnt_q <= rep_cnt_q + REP_ONE;
            end
          end else begin
            rep_cnt_q <= '0;
          end
`endif
        end
        default: begin
          acc_q   <= 10'd0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign button       = button_q;
  assign button_valid = valid_q;
  assign chord_err    = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_button_chord_capture.sv
// -----------------------------------------------------------------------------
// Testbench for button_chord_capture (default parameters, repeat disabled).
// Each scenario is a table of raw key levels, one entry per clock cycle. A
// press-level model derives the expected output trace from that table. The
// trace is compared every cycle, and literal expectations pin key events.
// -----------------------------------------------------------------------------
module tb_button_chord_capture;
  localparam int CW   = 8;
  localparam int DEB  = 4;
  localparam int MAXN = 64;

  logic       clk = 1'b0;
  logic       clear;
  logic [9:0] button_raw;
  logic [9:0] button;
  logic       button_valid;
  logic       chord_err;
  logic       busy;

  always #5 clk = ~clk;

  button_chord_capture #(.CHORD_WINDOW(CW), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk          (clk),
    .clear        (clear),
    .button_raw   (button_raw),
    .button       (button),
    .button_valid (button_valid),
    .chord_err    (chord_err),
    .busy         (busy)
  );

  int checks = 0;
  int passed = 0;

  logic [9:0] raw_vec  [MAXN];
  logic [9:0] exp_btn  [MAXN];
  logic       exp_val  [MAXN];
  logic       exp_err  [MAXN];
  logic       exp_busy [MAXN];
  logic [9:0] obs_btn  [MAXN];
  logic       obs_val  [MAXN];
  logic       obs_err  [MAXN];
  logic       obs_busy [MAXN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, req);
  endtask

  function automatic logic legal_code(input logic [9:0] c);
    legal_code = 1'b0;
    for (int k = 0; k < 10; k++) if (c == (10'd1 << k)) legal_code = 1'b1;
    if (c == 10'h201 || c == 10'h202 || c == 10'h204 || c == 10'h208 ||
        c == 10'h300 || c == 10'h380) legal_code = 1'b1;
  endfunction

  // Expected trace from press-level rules. The FSM at edge t sees raw[t-2].
  // A press starting at sample i needs samples i..i+CW to be nonzero.
  // It emits OR(samples i..i+CW-1) after edge i+CW. It is then busy until
  // DEB consecutive zero samples seen from edge i+CW+2 onward.
  task automatic build_model(input int n);
    logic [9:0] s [MAXN];
    logic [9:0] code;
    int t, i, glitch, z, e;
    for (int k = 0; k < MAXN; k++) begin
      s[k] = (k >= 2 && k - 2 < n) ? raw_vec[k-2] : 10'd0;
      exp_btn[k] = 10'd0; exp_val[k] = 1'b0; exp_err[k] = 1'b0; exp_busy[k] = 1'b0;
    end
    t = 0;
    while (t < n) begin
      if (s[t] == 10'd0) begin
        t++;
        continue;
      end
      i = t;
      glitch = -1;
      for (int j = i + 1; j <= i + CW && j < n; j++)
        if (s[j] == 10'd0 && glitch < 0) glitch = j;
      if (glitch >= 0) begin
        for (int b = i; b < glitch; b++) exp_busy[b] = 1'b1;
        t = glitch + 1;
        continue;
      end
      if (i + CW >= n) begin
        for (int b = i; b < n; b++) exp_busy[b] = 1'b1;
        break;
      end
      code = 10'd0;
      for (int j = i; j < i + CW; j++) code = code | s[j];
      if (legal_code(code)) begin
        exp_btn[i+CW] = code;
        exp_val[i+CW] = 1'b1;
      end else begin
        exp_err[i+CW] = 1'b1;
      end
      z = 0;
      e = n;
      for (int j = i + CW + 2; j < n && e == n; j++) begin
        if (s[j] == 10'd0) z++; else z = 0;
        if (z == DEB) e = j;
      end
      for (int b = i; b < e && b < n; b++) exp_busy[b] = 1'b1;
      t = e + 1;
    end
  endtask

  // Reset, then play raw_vec for n cycles, comparing every cycle.
  task automatic run_vec(input string tag, input int n);
    build_model(n);
    clear = 1'b1;
    button_raw = 10'd0;
    repeat (2) @(negedge clk);
    check({tag, "_reset"}, {button, button_valid, chord_err, busy}, 13'd0);
    clear = 1'b0;
    for (int t = 0; t < n; t++) begin
      button_raw = raw_vec[t];
      @(posedge clk);
      @(negedge clk);
      obs_btn[t] = button; obs_val[t] = button_valid;
      obs_err[t] = chord_err; obs_busy[t] = busy;
      if ({button, button_valid, chord_err, busy} !==
          {exp_btn[t], exp_val[t], exp_err[t], exp_busy[t]})
        $display("FAIL %s cyc%0d: got btn=%h v=%b e=%b busy=%b, want btn=%h v=%b e=%b busy=%b",
                 tag, t, button, button_valid, chord_err, busy,
                 exp_btn[t], exp_val[t], exp_err[t], exp_busy[t]);
      else passed++;
      checks++;
    end
  endtask

  function automatic int count_val(input int n);
    count_val = 0;
    for (int t = 0; t < n; t++) if (obs_val[t]) count_val++;
  endfunction

  function automatic int count_err(input int n);
    count_err = 0;
    for (int t = 0; t < n; t++) if (obs_err[t]) count_err++;
  endfunction

  initial begin
    clear = 1'b1;
    button_raw = 10'd0;

    // Single digit 2: pulse after edge 10, busy drops after release.
    for (int t = 0; t < MAXN; t++) raw_vec[t] = (t < 20) ? 10'h004 : 10'd0;
    run_vec("digit2", 40);
    check("digit2_valid_t10", {31'd0, obs_val[10]}, 32'd1);
    check("digit2_code", {22'd0, obs_btn[10]}, 32'h004);
    check("digit2_pulses", count_val(40), 32'd1);
    check("digit2_busy_end", {31'd0, obs_busy[39]}, 32'd0);

    // 9 first, 0 joins at cycle 3: one ADD pulse.
    for (int t = 0; t < MAXN; t++)
      raw_vec[t] = (t < 3) ? 10'h200 : (t < 23) ? 10'h201 : 10'd0;
    run_vec("add", 40);
    check("add_code", {22'd0, obs_btn[10]}, 32'h201);
    check("add_pulses", count_val(40), 32'd1);

    // Keys 1+2: illegal chord.
    for (int t = 0; t < MAXN; t++) raw_vec[t] = (t < 20) ? 10'h006 : 10'd0;
    run_vec("illegal", 40);
    check("illegal_err_t10", {31'd0, obs_err[10]}, 32'd1);
    check("illegal_err_cnt", count_err(40), 32'd1);
    check("illegal_valid_cnt", count_val(40), 32'd0);

    // Two-cycle glitch on key 3.
    for (int t = 0; t < MAXN; t++) raw_vec[t] = (t < 2) ? 10'h008 : 10'd0;
    run_vec("glitch", 16);
    check("glitch_strobes", count_val(16) + count_err(16), 32'd0);
    check("glitch_busy3", {31'd0, obs_busy[3]}, 32'd1);
    check("glitch_busy4", {31'd0, obs_busy[4]}, 32'd0);

    // Released exactly at the window's closing edge: no strobe.
    for (int t = 0; t < MAXN; t++) raw_vec[t] = (t < 8) ? 10'h008 : 10'd0;
    run_vec("win_short", 24);
    check("win_short_strobes", count_val(24) + count_err(24), 32'd0);
    check("win_short_busy10", {31'd0, obs_busy[10]}, 32'd0);

    // One cycle longer: emits.
    for (int t = 0; t < MAXN; t++) raw_vec[t] = (t < 9) ? 10'h008 : 10'd0;
    run_vec("win_exact", 24);
    check("win_exact_valid_t10", {31'd0, obs_val[10]}, 32'd1);

    // Bounce during release restarts the debounce count.
    for (int t = 0; t < MAXN; t++)
      raw_vec[t] = (t < 15 || t == 16) ? 10'h008 : 10'd0;
    run_vec("bounce", 40);
    check("bounce_pulses", count_val(40), 32'd1);
    check("bounce_busy21", {31'd0, obs_busy[21]}, 32'd1);
    check("bounce_busy22", {31'd0, obs_busy[22]}, 32'd0);

    // Key added after the window closes is ignored.
    for (int t = 0; t < MAXN; t++)
      raw_vec[t] = (t < 12) ? 10'h001 : (t < 20) ? 10'h003 : 10'd0;
    run_vec("late", 40);
    check("late_code", {22'd0, obs_btn[10]}, 32'h001);
    check("late_pulses", count_val(40), 32'd1);

    // EQUAL chord.
    for (int t = 0; t < MAXN; t++) raw_vec[t] = (t < 20) ? 10'h300 : 10'd0;
    run_vec("equal", 40);
    check("equal_code", {22'd0, obs_btn[10]}, 32'h300);

    // Clear asserted mid-GATHER of CLEAR chord.
    clear = 1'b1;
    button_raw = 10'd0;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    button_raw = 10'h380;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_strobe", {30'd0, button_valid, chord_err}, 32'd0);
    end
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #2 clear = 1'b1;
    #1 check("abort_outputs", {19'd0, button, button_valid, chord_err, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_held", {19'd0, button, button_valid, chord_err, busy}, 32'd0);
    for (int t = 0; t < MAXN; t++) raw_vec[t] = (t < 20) ? 10'h380 : 10'd0;
    run_vec("clr_chord", 40);
    check("clr_chord_code", {22'd0, obs_btn[10]}, 32'h380);
    check("clr_chord_pulses", count_val(40), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/button_chord_capture.md
Name: button_chord_capture

Overview:
- Upstream stage that conditions the raw 10-key pad and feeds the calculator FSM's 10-bit `button` input.
- Synchronizes the keys and gathers simultaneously pressed keys into one chord within a settle window, for example 9+0 for add or 9+8+7 for clear.
- Issues each legal key code as a single-cycle registered pulse, then waits for a debounced full release before accepting the next press.
- Downstream sees `button` equal to 0 on every cycle except the emit cycle.

Parameters:
- CHORD_WINDOW, 8: number of synchronized samples ORed into the chord after the first key is detected (minimum 1).
- DEBOUNCE_CYCLES, 4: number of consecutive all-zero synchronized samples required to declare release (minimum 1).

Ports:
- clk  input  1  system clock; all state on the rising edge.
- clear  input  1  asynchronous, active-high reset.
- button_raw  input  10  raw key levels, asynchronous to clk; bit n = key n.
- button  output  10  captured key code; nonzero only while button_valid=1.
- button_valid  output  1  one-cycle strobe qualifying button.
- chord_err  output  1  one-cycle strobe for an illegal chord.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: clk is the single clock; clear is asynchronous and active-high.
  - While clear is high: sync flops, chord accumulator and counters are 0; state is IDLE.
  - Outputs are 0: button=0, button_valid=0, chord_err=0, busy=0.
  - clear asserted mid-GATHER, EMIT or RELEASE aborts with no pulse.
- Synchronizer: button_raw passes through a 2-flop synchronizer to give btn_s. FSM logic uses btn_s only.
- Counters: width $clog2(max parameter)+1. No wrap-around; each counter saturates at its terminal value.
- IDLE:
  - btn_s==0: stay.
  - btn_s!=0: acc<=btn_s, win_cnt<=1, go to GATHER.
- GATHER:
  - Each edge: acc<=acc|btn_s; win_cnt increments.
  - btn_s==0 on any GATHER edge: glitch; go to IDLE with no output and clear acc.
  - win_cnt==CHORD_WINDOW with btn_s!=0: go to EMIT.
- EMIT (one cycle, outputs registered):
  - acc legal: button=acc, button_valid=1.
  - acc illegal: chord_err=1, button=0.
  - Always go to RELEASE; rel_cnt<=0.
- Legal codes:
  - Single-hot 0..9: 10'b00_0000_0001 through 10'b10_0000_0000.
  - ADD 10'b10_0000_0001, SUB 10'b10_0000_0010, MUL 10'b10_0000_0100, DIV 10'b10_0000_1000.
  - EQUAL 10'b11_0000_0000, CLEAR 10'b11_1000_0000.
- RELEASE:
  - btn_s==0: rel_cnt++.
  - btn_s!=0: rel_cnt<=0; new keys are ignored, not accumulated.
  - rel_cnt==DEBOUNCE_CYCLES: go to IDLE and clear acc.
- Latency: button_valid is high in the cycle after rising edge 2+CHORD_WINDOW. Edge 0 is the first edge at which button_raw!=0 is captured by the first sync flop.
- At most one strobe (button_valid or chord_err) per press/release cycle. The two strobes are never high together.
- A key held indefinitely produces exactly one strobe (no auto-repeat unless the optional feature is enabled).
- Keys added after the window closes are ignored until full release.
- Parameter values below 1 are illegal.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- When defined:
  - In RELEASE, if btn_s equals acc continuously for 16*CHORD_WINDOW cycles, re-emit the same legal code, one-cycle button_valid.
  - Repeat every 16*CHORD_WINDOW cycles while held unchanged.
  - Applies to single-hot digits only, never to operator, EQUAL or CLEAR chords.
  - Any change of btn_s restarts the repeat timer.
- When undefined: no repeat logic is compiled; behaviour is exactly as above.

Test Plan:
- Reset then raw=10'h004 held 20 cycles, released 10 cycles (defaults) -> button=10'h004 with button_valid=1 in the cycle after edge 10, exactly one pulse, busy returns to 0.
- Raw 10'h200 at edge 0, then 10'h201 from edge 3 -> one pulse of button=10'h201 (ADD), no pulse for 10'h200 alone.
- Raw 10'h006 (keys 1+2) held -> chord_err=1 for one cycle, button_valid never high, button stays 0.
- Raw 10'h008 pulsed for 2 cycles then 0 -> no strobe, returns to IDLE. Bounce during RELEASE (0,1,0,0,0,0 on bit 3) -> release counter restarts, IDLE after 4 clean zeros, no second pulse.
- Assert clear during GATHER of 10'h380 -> all outputs 0 immediately, no strobe. After deassert, a fresh 10'h380 press -> button=10'h380 pulse.
- With BUTTON_AUTO_REPEAT_EN defined, hold 10'h010 for 400 cycles -> first pulse at edge 10, then repeats every 128 cycles. Hold 10'h201 -> one pulse only.
